// File: rtl/inst_mem_responder.sv
// Memory-side responder for the CPU readM/writeM handshake: word-addressed array,
// programmable response latency, side-band preload port and transaction counters.
module inst_mem_responder #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  logic [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 is_read_q, is_read_d;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 ready_q, ack_q, busy_q;
  logic [WORD_SIZE-1:0] nreads_q, nwrites_q;
  logic                 resp_entry;
  logic                 unused_addr;

  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  assign unused_addr = ^address[WORD_SIZE-1:ADDR_BITS];

  // WAIT is visited for every latency; cnt runs down to 0 so the strobe
  // rises exactly LATENCY edges after the accepting edge.
  assign resp_entry = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    case (state_q)
      IDLE: begin
        if (readM || writeM) begin
          addr_d    = address[ADDR_BITS-1:0];
          wdata_d   = data;
          is_read_d = readM;
          cnt_d     = 4'(LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!readM && !writeM) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      nreads_q  <= '0;
      nwrites_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= resp_entry && is_read_q;
      ack_q   <= resp_entry && !is_read_q;
      busy_q  <= (state_d != IDLE);
      if (state_q == RESP &&  is_read_q) nreads_q  <= nreads_q  + WORD_SIZE'(1);
      if (state_q == RESP && !is_read_q) nwrites_q <= nwrites_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    is_read_q <= is_read_d;
    if (resp_entry) rdata_q <= mem[addr_q];
  end

  // Preload is written last so it wins over a same-edge response write.
  always_ff @(posedge clk) begin
    if (reset_n && resp_entry && !is_read_q) mem[addr_q] <= wdata_q;
    if (load_en) mem[load_addr] <= load_data;
  end

  assign data       = ready_q ? rdata_q : 'z;
  assign inputReady = ready_q;
  assign ackOutput  = ack_q;
  assign busy       = busy_q;
  assign num_reads  = nreads_q;
  assign num_writes = nwrites_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized self-checking bench for inst_mem_responder against a transaction-level model.
module tb_inst_mem_responder;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, readM, writeM, load_en, tb_oe;
  logic [15:0] address, load_data, tb_wdata;
  logic [7:0]  load_addr;
  tri0  [15:0] data;
  logic        inputReady, ackOutput, busy;
  logic [15:0] num_reads, num_writes;

  assign data = tb_oe ? tb_wdata : 'z;

  inst_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM), .address(address),
    .data(data), .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  // Narrow, single-cycle-latency instance: makes counter wrap reachable quickly.
  logic       readM2, writeM2, load_en2;
  logic [7:0] address2, load_data2;
  logic [3:0] load_addr2;
  tri0  [7:0] data2;
  logic       inputReady2, ackOutput2, busy2;
  logic [7:0] num_reads2, num_writes2;

  inst_mem_responder #(.WORD_SIZE(8), .ADDR_BITS(4), .LATENCY(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .readM(readM2), .writeM(writeM2), .address(address2),
    .data(data2), .inputReady(inputReady2), .ackOutput(ackOutput2), .busy(busy2),
    .load_en(load_en2), .load_addr(load_addr2), .load_data(load_data2),
    .num_reads(num_reads2), .num_writes(num_writes2)
  );

  logic [15:0] mdl_mem [256];
  logic [15:0] exp_reads, exp_writes;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mdl_mem[a] = d;
  endtask

  // One CPU transaction. hold = extra cycles the request stays high after the strobe;
  // load_e = 1..LAT puts a preload at edge t0+load_e (0 = none).
  task automatic txn(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                     input int hold, input int load_e, input logic [7:0] la, input logic [15:0] ld);
    logic [7:0]  idx;
    logic [15:0] exp_rd, exp_bus;
    int          k_idle;
    idx = addr[7:0];
    @(negedge clk);
    readM = rd; writeM = wr; address = addr; tb_wdata = wd; tb_oe = 1'b1;
    @(posedge clk);
    if (load_e > 0 && load_e < int'(LAT)) mdl_mem[la] = ld;
    exp_rd = mdl_mem[idx];
    if (!rd) mdl_mem[idx] = wd;
    if (load_e == int'(LAT)) mdl_mem[la] = ld;
    k_idle = (hold == 0) ? int'(LAT) + 2 : int'(LAT) + hold + 1;
    for (int k = 0; k <= k_idle; k++) begin
      @(negedge clk);
      if (k == 0) tb_oe = 1'b0;
      load_en = (load_e > 0 && k == load_e - 1); load_addr = la; load_data = ld;
      check("busy", busy, k < k_idle);
      check("inputReady", inputReady, rd && k == int'(LAT));
      check("ackOutput", ackOutput, !rd && k == int'(LAT));
      if (k >= 1) begin
        exp_bus = (rd && k == int'(LAT)) ? exp_rd : 16'h0000;
        check("data", data, exp_bus);
      end
      if (k == int'(LAT) + hold) begin readM = 1'b0; writeM = 1'b0; end
    end
    if (rd) exp_reads = exp_reads + 16'd1;
    else    exp_writes = exp_writes + 16'd1;
    check("num_reads", num_reads, exp_reads);
    check("num_writes", num_writes, exp_writes);
  endtask

  initial begin
    logic [15:0] a, wd, ld;
    logic [7:0]  la;
    bit          rd, wr;
    reset_n = 1'b0; readM = 1'b0; writeM = 1'b0; address = '0; tb_oe = 1'b0; tb_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    readM2 = 1'b0; writeM2 = 1'b0; address2 = '0; load_en2 = 1'b0; load_addr2 = '0; load_data2 = '0;
    exp_reads = '0; exp_writes = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_inputReady", inputReady, 0);
    check("rst_ackOutput", ackOutput, 0);
    check("rst_data", data, 16'h0000);
    check("rst_num_reads", num_reads, 0);
    check("rst_num_writes", num_writes, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom) | 16'h0001);
    preload(8'h10, 16'hA55A);
    preload(8'h07, 16'h00FF);

    txn(1, 0, 16'h0010, 16'h0000, 0, 0, 8'h00, 16'h0000);
    txn(0, 1, 16'h0003, 16'h1234, 0, 0, 8'h00, 16'h0000);
    txn(1, 0, 16'h0003, 16'h0000, 0, 0, 8'h00, 16'h0000);
    txn(1, 1, 16'h0007, 16'hBEEF, 0, 0, 8'h00, 16'h0000);
    txn(1, 0, 16'h0007, 16'h0000, 0, 0, 8'h00, 16'h0000);
    txn(1, 0, 16'h0010, 16'h0000, 5, 0, 8'h00, 16'h0000);
    txn(1, 0, 16'h0110, 16'h0000, 0, 0, 8'h00, 16'h0000);
    txn(0, 1, 16'h0020, 16'h1111, 0, LAT, 8'h20, 16'h5555);
    txn(1, 0, 16'h0020, 16'h0000, 0, 0, 8'h00, 16'h0000);
    txn(1, 0, 16'h0021, 16'h0000, 0, LAT, 8'h21, 16'h6666);
    txn(1, 0, 16'h0021, 16'h0000, 0, 0, 8'h00, 16'h0000);

    // Reset while the read is waiting.
    @(negedge clk);
    readM = 1'b1; address = 16'h0010;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_inputReady", inputReady, 0);
    check("abort_data", data, 16'h0000);
    check("abort_num_reads", num_reads, 0);
    check("abort_num_writes", num_writes, 0);
    readM = 1'b0; reset_n = 1'b1;
    exp_reads = '0; exp_writes = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_strobe", inputReady, 0);
    end
    txn(1, 0, 16'h0010, 16'h0000, 0, 0, 8'h00, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      a  = 16'($urandom);
      wd = 16'($urandom);
      la = $urandom_range(0, 1) ? a[7:0] : 8'($urandom);
      ld = 16'($urandom);
      txn(rd, wr, a, wd, $urandom_range(0, 3), $urandom_range(0, LAT), la, ld);
    end

    // Counter wrap and address alias on the narrow instance.
    @(negedge clk);
    load_en2 = 1'b1; load_addr2 = 4'h5; load_data2 = 8'h3C;
    @(negedge clk);
    load_en2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      readM2 = 1'b1; address2 = 8'h15;
      @(negedge clk);
      if (i == 0) check("w_early_strobe", inputReady2, 0);
      @(negedge clk);
      if (i == 0 || i == 255) begin
        check("w_inputReady", inputReady2, 1);
        check("w_alias_data", data2, 8'h3C);
      end
      readM2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (i == 254) check("w_num_reads_ff", num_reads2, 8'hFF);
    end
    check("w_num_reads_wrap", num_reads2, 8'h00);
    check("w_num_writes", num_writes2, 8'h00);
    check("w_busy", busy2, 0);
    check("w_ack", ackOutput2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
